// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// Contents: XLEN/AW widths, the buffered writeback entry, and the writeback source select.
// Imported by wb_fifo and rf_writeback_arbiter.
package rf_wb_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LQ   = 2'd2
  } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t holding long-latency results until the RF port is free.
// Ports: clk/reset (async, active-high), i_push/i_din, i_pop/o_dout (head, combinational),
//        o_full, o_empty, o_count (occupancy, 0..DEPTH). Push when full / pop when empty are ignored.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  wb_entry_t                i_din,
  input  logic                     i_pop,
  output wb_entry_t                o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_cnt;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers are exactly PW bits wide, so wrap modulo DEPTH falls out of the width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges the ALU result (priority, never stalled) and buffered LSU/MDU results into the single RF write port.
// Ports: ALU wb (valid/rd/data), LSU wb (valid/ready/rd/data), issue (valid/rd), pending scoreboard,
//        stall_req, lq_count, sticky proto_err, registered RF write port. Optional macro WB_FORWARD_EN adds
//        fwd_rs{1,2}_addr/hit/data bypass of the in-flight RF write. Reset: async, active-high.
module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_wb_valid,
  input  logic [AW-1:0]               alu_wb_rd,
  input  logic [XLEN-1:0]             alu_wb_data,
  input  logic                        lsu_wb_valid,
  output logic                        lsu_wb_ready,
  input  logic [AW-1:0]               lsu_wb_rd,
  input  logic [XLEN-1:0]             lsu_wb_data,
  input  logic                        issue_valid,
  input  logic [AW-1:0]               issue_rd,
  output logic [2**AW-1:0]            pending,
  output logic                        stall_req,
  output logic [$clog2(LQ_DEPTH):0]   lq_count,
  output logic                        proto_err,
`ifdef WB_FORWARD_EN
  input  logic [AW-1:0]               fwd_rs1_addr,
  input  logic [AW-1:0]               fwd_rs2_addr,
  output logic                        fwd_rs1_hit,
  output logic                        fwd_rs2_hit,
  output logic [XLEN-1:0]             fwd_rs1_data,
  output logic [XLEN-1:0]             fwd_rs2_data,
`endif
  output logic                        reg_write_enable,
  output logic [AW-1:0]               reg_write_addr,
  output logic [XLEN-1:0]             reg_write_data
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_src_e          w_src;
  wb_entry_t        w_head;
  wb_entry_t        w_lsu_entry;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [2**AW-1:0] w_pend_nxt;
  logic             w_err_now;
  logic [SW-1:0]    w_starve_nxt;

  logic [2**AW-1:0] r_pend;
  logic [SW-1:0]    r_starve;
  logic             r_stall;
  logic             r_err;
  logic             r_we;
  logic [AW-1:0]    r_wa;
  logic [XLEN-1:0]  r_wd;

  // An ALU write to x0 is dropped, which frees the port for the FIFO head.
  always_comb begin
    w_src = WB_NONE;
    if (alu_wb_valid && alu_wb_rd != '0) w_src = WB_ALU;
    else if (!w_empty)                   w_src = WB_LQ;
  end

  assign w_pop        = (w_src == WB_LQ);
  assign w_push       = lsu_wb_valid && !w_full;
  assign lsu_wb_ready = !w_full;
  assign w_lsu_entry  = '{rd: lsu_wb_rd, data: lsu_wb_data};

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_lsu_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (lq_count)
  );

  // Clear on pop first, then set on issue, so a same-cycle set of the same rd wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pop) w_pend_nxt[w_head.rd] = 1'b0;
    if (issue_valid && issue_rd != '0) w_pend_nxt[issue_rd] = 1'b1;
  end

  // Results for x0 never had a pending bit, so they are not treated as protocol errors.
  assign w_err_now = (issue_valid && issue_rd != '0 && r_pend[issue_rd]) ||
                     (w_push && lsu_wb_rd != '0 && !r_pend[lsu_wb_rd]);

  always_comb begin
    if (w_pop || w_empty)                   w_starve_nxt = '0;
    else if (r_starve == SW'(STARVE_MAX))   w_starve_nxt = r_starve;
    else                                    w_starve_nxt = r_starve + 1'b1;
  end

  // Idle write port drives addr/data to zero so the RF bus is quiet when nothing is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_wa     <= '0;
      r_wd     <= '0;
      r_pend   <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (w_src)
        WB_ALU: begin
          r_we <= 1'b1;
          r_wa <= alu_wb_rd;
          r_wd <= alu_wb_data;
        end
        WB_LQ: begin
          r_we <= (w_head.rd != '0);
          r_wa <= w_head.rd;
          r_wd <= (w_head.rd != '0) ? w_head.data : '0;
        end
        default: begin
          r_we <= 1'b0;
          r_wa <= '0;
          r_wd <= '0;
        end
      endcase
      r_pend   <= w_pend_nxt;
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == SW'(STARVE_MAX));
      r_err    <= r_err | w_err_now;
    end
  end

  assign pending          = r_pend;
  assign stall_req        = r_stall;
  assign proto_err        = r_err;
  assign reg_write_enable = r_we;
  assign reg_write_addr   = r_wa;
  assign reg_write_data   = r_wd;

`ifdef WB_FORWARD_EN
  // Bypass the write that the RF commits at the end of this cycle.
  assign fwd_rs1_hit  = r_we && (fwd_rs1_addr == r_wa) && (fwd_rs1_addr != '0);
  assign fwd_rs2_hit  = r_we && (fwd_rs2_addr == r_wa) && (fwd_rs2_addr != '0);
  assign fwd_rs1_data = r_wd;
  assign fwd_rs2_data = r_wd;
`endif
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;
  import rf_wb_pkg::*;

  localparam int D  = 4;
  localparam int SM = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_wb_valid;
  logic [4:0]      alu_wb_rd;
  logic [31:0]     alu_wb_data;
  logic            lsu_wb_valid;
  logic            lsu_wb_ready;
  logic [4:0]      lsu_wb_rd;
  logic [31:0]     lsu_wb_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [31:0]     pending;
  logic            stall_req;
  logic [2:0]      lq_count;
  logic            proto_err;
  logic            reg_write_enable;
  logic [4:0]      reg_write_addr;
  logic [31:0]     reg_write_data;
`ifdef WB_FORWARD_EN
  logic [4:0]      fwd_rs1_addr, fwd_rs2_addr;
  logic            fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0]     fwd_rs1_data, fwd_rs2_data;
`endif

  always #5 clk = ~clk;

  rf_writeback_arbiter #(.LQ_DEPTH(D), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready), .lsu_wb_rd(lsu_wb_rd),
    .lsu_wb_data(lsu_wb_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .pending(pending), .stall_req(stall_req), .lq_count(lq_count), .proto_err(proto_err),
`ifdef WB_FORWARD_EN
    .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
`endif
    .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of buffered results, per-register pending bits, starve count.
  wb_entry_t   mq[$];
  logic [31:0] m_pend;
  int          m_starve;
  bit          m_stall, m_err, m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = '0; m_starve = 0; m_stall = 0; m_err = 0;
    m_we = 0; m_wa = '0; m_wd = '0;
  endtask

  task automatic check_all();
    chk("we",      64'(reg_write_enable), 64'(m_we));
    chk("addr",    64'(reg_write_addr),   64'(m_wa));
    chk("data",    64'(reg_write_data),   64'(m_wd));
    chk("pending", 64'(pending),          64'(m_pend));
    chk("stall",   64'(stall_req),        64'(m_stall));
    chk("count",   64'(lq_count),         64'(mq.size()));
    chk("err",     64'(proto_err),        64'(m_err));
  endtask

  // One clock: drive inputs, check ready, advance model across the edge, check outputs.
  task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                     input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input bit iv, input logic [4:0] ird);
    bit alu, pop, acc, was_empty;
    wb_entry_t h;
    alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = adat;
    lsu_wb_valid = lv; lsu_wb_rd = lrd; lsu_wb_data = ldat;
    issue_valid = iv; issue_rd = ird;
    alu = av && (ard != 0);
    was_empty = (mq.size() == 0);
    pop = !alu && !was_empty;
    h = '0;
    if (pop) h = mq[0];
    acc = lv && (mq.size() < D);
    #1;
    chk("ready", 64'(lsu_wb_ready), 64'(mq.size() < D));
    @(posedge clk);
    #1;
    if (alu) begin
      m_we = 1; m_wa = ard; m_wd = adat;
    end else if (pop && h.rd != 0) begin
      m_we = 1; m_wa = h.rd; m_wd = h.data;
    end else begin
      m_we = 0; m_wa = '0; m_wd = '0;
    end
    if (iv && ird != 0 && m_pend[ird]) m_err = 1;
    if (acc && lrd != 0 && !m_pend[lrd]) m_err = 1;
    if (pop) m_pend[h.rd] = 1'b0;
    if (iv && ird != 0) m_pend[ird] = 1'b1;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back('{rd: lrd, data: ldat});
    if (pop || was_empty) m_starve = 0;
    else if (m_starve < SM) m_starve++;
    m_stall = (m_starve == SM);
    check_all();
  endtask

  task automatic idle();
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
  endtask

  // Called at posedge+1: reset is raised mid-cycle and outputs must clear without a clock.
  task automatic do_reset();
    alu_wb_valid = 0; lsu_wb_valid = 0; issue_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_we",      64'(reg_write_enable), 64'd0);
    chk("rst_addr",    64'(reg_write_addr),   64'd0);
    chk("rst_data",    64'(reg_write_data),   64'd0);
    chk("rst_pending", 64'(pending),          64'd0);
    chk("rst_stall",   64'(stall_req),        64'd0);
    chk("rst_count",   64'(lq_count),         64'd0);
    chk("rst_err",     64'(proto_err),        64'd0);
    chk("rst_ready",   64'(lsu_wb_ready),     64'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alu_wb_valid = 0; alu_wb_rd = '0; alu_wb_data = '0;
    lsu_wb_valid = 0; lsu_wb_rd = '0; lsu_wb_data = '0;
    issue_valid = 0; issue_rd = '0;
`ifdef WB_FORWARD_EN
    fwd_rs1_addr = '0; fwd_rs2_addr = '0;
`endif
    model_reset();
    #12;
    check_all();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: ALU alone, then ALU to x0
    cyc(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0);
    chk("t1_we",   64'(reg_write_enable), 64'd1);
    chk("t1_addr", 64'(reg_write_addr),   64'd5);
    chk("t1_data", 64'(reg_write_data),   64'h1234);
    cyc(1, 5'd0, 32'h5555, 0, 5'd0, 32'd0, 0, 5'd0);
    chk("t1_x0_we", 64'(reg_write_enable), 64'd0);

    // 2: issue rd7, LSU result, written two cycles after accept
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7);
    chk("t2_pend_set", 64'(pending[7]), 64'd1);
    cyc(0, 5'd0, 32'd0, 1, 5'd7, 32'hCAFE, 0, 5'd0);
    chk("t2_we_early", 64'(reg_write_enable), 64'd0);
    idle();
    chk("t2_we",   64'(reg_write_enable), 64'd1);
    chk("t2_addr", 64'(reg_write_addr),   64'd7);
    chk("t2_data", 64'(reg_write_data),   64'hCAFE);
    chk("t2_pend_clr", 64'(pending[7]),   64'd0);

    // 3: fill FIFO while ALU owns the port, then drain in order
    for (int i = 0; i < 4; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'(10 + i));
    for (int i = 0; i < 4; i++) cyc(1, 5'd1, 32'(i), 1, 5'(10 + i), 32'hA0 + 32'(i), 0, 5'd0);
    chk("t3_count", 64'(lq_count),     64'd4);
    chk("t3_ready", 64'(lsu_wb_ready), 64'd0);
    chk("t3_stall", 64'(stall_req),    64'd1);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t3_order_addr", 64'(reg_write_addr), 64'(10 + i));
      chk("t3_order_data", 64'(reg_write_data), 64'hA0 + 64'(i));
      if (i == 0) chk("t3_stall_drop", 64'(stall_req), 64'd0);
    end

    // 4: double issue to rd3 -> sticky proto_err
    chk("t4_err_clean", 64'(proto_err), 64'd0);
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3);
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3);
    chk("t4_err", 64'(proto_err), 64'd1);
    idle(); idle();
    chk("t4_err_sticky", 64'(proto_err), 64'd1);

    // 5: reset with count 3 and stall asserted
    for (int i = 0; i < 3; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'(20 + i));
    for (int i = 0; i < 3; i++) cyc(1, 5'd2, 32'(i), 1, 5'(20 + i), 32'hB0 + 32'(i), 0, 5'd0);
    cyc(1, 5'd2, 32'd9, 0, 5'd0, 32'd0, 0, 5'd0);
    chk("t5_count", 64'(lq_count),  64'd3);
    chk("t5_stall", 64'(stall_req), 64'd1);
    do_reset();

`ifdef WB_FORWARD_EN
    // 6: forwarding of the in-flight write
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9);
    cyc(0, 5'd0, 32'd0, 1, 5'd9, 32'h9999, 0, 5'd0);
    idle();
    fwd_rs1_addr = 5'd9; fwd_rs2_addr = 5'd0;
    #1;
    chk("t6_hit1",  64'(fwd_rs1_hit),  64'd1);
    chk("t6_data1", 64'(fwd_rs1_data), 64'h9999);
    chk("t6_hit0",  64'(fwd_rs2_hit),  64'd0);
    fwd_rs1_addr = 5'd8;
    #1;
    chk("t6_miss",  64'(fwd_rs1_hit),  64'd0);
    fwd_rs1_addr = '0;
`endif

    // Randomized traffic against the model, with resets between rounds.
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 400; n++) begin
        bit av, lv, iv;
        logic [4:0] ard, lrd, ird;
        av  = m_stall ? 1'b0 : ($urandom_range(0, 99) < 50);
        ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        lv  = ($urandom_range(0, 99) < 45);
        lrd = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        iv  = ($urandom_range(0, 99) < 30);
        ird = 5'($urandom_range(0, 31));
        cyc(av, ard, $urandom, lv, lrd, $urandom, iv, ird);
      end
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
